// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy scoreboard.
// Reads are combinational with optional same-cycle write forwarding.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int   DEPTH = 1 << ADDR_WIDTH;
  localparam logic ZR    = (ZERO_REG != 0);
  localparam logic BP    = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] storage_q [DEPTH];
  logic [DATA_WIDTH-1:0] storage_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q;
  logic [ADDR_WIDTH:0]   busy_cnt_d;
  logic [DEPTH-1:0]      wr_hit_s;
  logic [DEPTH-1:0]      rsv_hit_s;
  logic [DEPTH-1:0]      set_new_s;
  logic [DEPTH-1:0]      clr_new_s;
  logic [ADDR_WIDTH-1:0] ra_s;

  function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Merge write ports per register; later ports override earlier ones.
  always_comb begin
    wr_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      storage_d[i] = storage_q[i];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))) begin
          wr_hit_s[i]  = 1'b1;
          storage_d[i] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          wr_hit_s[i]  = wr_hit_s[i];
        end
      end
    end
    wr_hit_s[0]  = wr_hit_s[0] & ~ZR;
    storage_d[0] = ZR ? '0 : storage_d[0];
  end

  // Scoreboard next state; a reservation beats a write-clear on the same index.
  always_comb begin
    rsv_hit_s           = '0;
    rsv_hit_s[rsv_addr] = rsv_en & ~(ZR & (rsv_addr == '0));
    busy_d              = (busy_q & ~wr_hit_s) | rsv_hit_s;
    set_new_s           = rsv_hit_s & ~busy_q;
    clr_new_s           = busy_q & wr_hit_s & ~rsv_hit_s;
    busy_cnt_d          = busy_cnt_q + popcount(set_new_s) - popcount(clr_new_s);
  end

  // Combinational read ports with optional forwarding of this cycle's writes.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra_s    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra_s = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (ZR && (ra_s == '0)) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_busy[k]                          = 1'b0;
      end else if (BP && rst_n && wr_hit_s[ra_s]) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = storage_d[ra_s];
        rd_busy[k]                          = 1'b0;
      end else begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = storage_q[ra_s];
        rd_busy[k]                          = busy_q[ra_s];
      end
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= storage_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dut_a has two write ports with bypass, dut_b one write port without bypass.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic [5:0]  a_busy_cnt;

  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_rsv_en;
  logic [4:0]  b_rsv_addr;
  logic [5:0]  b_busy_cnt;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2),
               .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .busy_cnt(a_busy_cnt)
  );

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(1),
               .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .busy_cnt(b_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr_en = 2'b00; a_wr_addr = 10'd0; a_wr_data = 64'd0;
    a_rsv_en = 1'b0; a_rsv_addr = 5'd0;
    b_wr_en = 1'b0; b_wr_addr = 5'd0; b_wr_data = 32'd0;
    b_rsv_en = 1'b0; b_rsv_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    a_rd_addr = 10'd0; b_rd_addr = 10'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {i[4:0], i[4:0]};
      b_rd_addr = {i[4:0], i[4:0]};
      #1;
      checks++;
      if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read_a idx=%0d: got data=%h busy=%b, expected 0/00", i, a_rd_data, a_rd_busy);
      end
      checks++;
      if (b_rd_data !== 64'd0 || b_rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read_b idx=%0d: got data=%h busy=%b, expected 0/00", i, b_rd_data, b_rd_busy);
      end
    end
    checks++;
    if (a_busy_cnt !== 6'd0 || b_busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_cnt: got a=%0d b=%0d, expected 0", a_busy_cnt, b_busy_cnt);
    end
  endtask

  task automatic test_write_read();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'd0, 32'hDEADBEEF};
    b_wr_en = 1'b1;  b_wr_addr = 5'd5;         b_wr_data = 32'hDEADBEEF;
    a_rd_addr = {5'd5, 5'd0};
    b_rd_addr = {5'd5, 5'd0};
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h, expected deadbeef", a_rd_data[63:32]);
    end
    checks++;
    if (b_rd_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle: got %h, expected 00000000", b_rd_data[63:32]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'hDEADBEEF || b_rd_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_then_read: got a=%h b=%h, expected deadbeef", a_rd_data[63:32], b_rd_data[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'd0, 32'h1234};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: got %h, expected 00000000", a_rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00 || a_busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL zero_reg: got data=%h busy=%b cnt=%0d, expected 0/00/0", a_rd_data, a_rd_busy, a_busy_cnt);
    end
  endtask

  task automatic test_scoreboard();
    a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
    tick();
    a_rsv_addr = 5'd7;
    tick();
    idle();
    a_rd_addr = {5'd7, 5'd3};
    #1;
    checks++;
    if (a_busy_cnt !== 6'd2 || a_rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL rsv_two: got cnt=%0d busy=%b, expected 2/11", a_busy_cnt, a_rd_busy);
    end
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'd0, 32'h33};
    #1;
    checks++;
    if (a_rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL busy_bypass: got %b, expected 10", a_rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a_busy_cnt !== 6'd1 || a_rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL write_clears: got cnt=%0d busy=%b, expected 1/10", a_busy_cnt, a_rd_busy);
    end
    a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
    tick();
    idle();
    #1;
    checks++;
    if (a_busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL rsv_again: got cnt=%0d, expected 1", a_busy_cnt);
    end
    // without forwarding, busy stays visible until the write edge
    b_rsv_en = 1'b1; b_rsv_addr = 5'd3;
    tick();
    idle();
    b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h77;
    b_rd_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if (b_rd_busy !== 2'b01 || b_busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL nobypass_busy: got busy=%b cnt=%0d, expected 01/1", b_rd_busy, b_busy_cnt);
    end
    tick();
    idle();
    #1;
    checks++;
    if (b_rd_busy !== 2'b00 || b_busy_cnt !== 6'd0 || b_rd_data[31:0] !== 32'h77) begin
      errors++;
      $display("FAIL nobypass_clear: got busy=%b cnt=%0d data=%h, expected 00/0/77", b_rd_busy, b_busy_cnt, b_rd_data[31:0]);
    end
  endtask

  task automatic test_rsv_write_same();
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'd0, 32'hA5};
    tick();
    idle();
    a_rd_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'hA5 || a_rd_busy[0] !== 1'b1 || a_busy_cnt !== 6'd2) begin
      errors++;
      $display("FAIL rsv_write_same: got data=%h busy=%b cnt=%0d, expected a5/1/2", a_rd_data[31:0], a_rd_busy[0], a_busy_cnt);
    end
  endtask

  task automatic test_multi_write();
    a_wr_en = 2'b11; a_wr_addr = {5'd4, 5'd4}; a_wr_data = {32'h22, 32'h11};
    a_rd_addr = {5'd4, 5'd4};
    #1;
    checks++;
    if (a_rd_data !== {32'h22, 32'h22}) begin
      errors++;
      $display("FAIL multi_bypass: got %h, expected 0000002200000022", a_rd_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h22 || a_busy_cnt !== 6'd2) begin
      errors++;
      $display("FAIL multi_write: got data=%h cnt=%0d, expected 22/2", a_rd_data[31:0], a_busy_cnt);
    end
    a_rsv_en = 1'b1; a_rsv_addr = 5'd10;
    tick();
    a_rsv_addr = 5'd11;
    tick();
    idle();
    a_wr_en = 2'b11; a_wr_addr = {5'd11, 5'd10}; a_wr_data = {32'hBB, 32'hAA};
    tick();
    idle();
    a_rd_addr = {5'd11, 5'd10};
    #1;
    checks++;
    if (a_busy_cnt !== 6'd2 || a_rd_busy !== 2'b00 || a_rd_data !== {32'hBB, 32'hAA}) begin
      errors++;
      $display("FAIL dual_clear: got cnt=%0d busy=%b data=%h, expected 2/00/000000bb000000aa", a_busy_cnt, a_rd_busy, a_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    a_rd_addr = {5'd9, 5'd4};
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_rd_data !== 64'd0 || a_busy_cnt !== 6'd0 || a_rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got data=%h cnt=%0d busy=%b, expected 0/0/00", a_rd_data, a_busy_cnt, a_rd_busy);
    end
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd6}; a_wr_data = {32'd0, 32'h66};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd12;
    a_rd_addr = {5'd6, 5'd0};
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_bypass: got %h, expected 00000000", a_rd_data[63:32]);
    end
    tick();
    checks++;
    if (a_rd_data[63:32] !== 32'h0 || a_busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_ignores_edge: got data=%h cnt=%0d, expected 0/0", a_rd_data[63:32], a_busy_cnt);
    end
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'h66) begin
      errors++;
      $display("FAIL bypass_after_release: got %h, expected 00000066", a_rd_data[63:32]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'h66 || a_busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL first_edge_after_reset: got data=%h cnt=%0d, expected 66/1", a_rd_data[63:32], a_busy_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i < 32; i++) begin
      a_rsv_en = 1'b1; a_rsv_addr = i[4:0];
      tick();
    end
    idle();
    #1;
    checks++;
    if (a_busy_cnt !== 6'd31) begin
      errors++;
      $display("FAIL all_busy: got %0d, expected 31", a_busy_cnt);
    end
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    tick();
    a_rsv_addr = 5'd31;
    tick();
    idle();
    #1;
    checks++;
    if (a_busy_cnt !== 6'd31) begin
      errors++;
      $display("FAIL no_wrap: got %0d, expected 31", a_busy_cnt);
    end
    a_rsv_en = 1'b1; a_rsv_addr = 5'd31;
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd31}; a_wr_data = {32'd0, 32'h31};
    tick();
    idle();
    a_wr_en = 2'b10; a_wr_addr = {5'd30, 5'd0}; a_wr_data = {32'h30, 32'd0};
    tick();
    idle();
    a_rd_addr = {5'd30, 5'd31};
    #1;
    checks++;
    if (a_busy_cnt !== 6'd30 || a_rd_busy !== 2'b01 || a_rd_data !== {32'h30, 32'h31}) begin
      errors++;
      $display("FAIL top_clear: got cnt=%0d busy=%b data=%h, expected 30/01/0000003000000031", a_busy_cnt, a_rd_busy, a_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_rsv_write_same();
    test_multi_write();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
